// File: rtl/vga_tile_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_tile_fetch                                                |
// | Purpose  : Text-mode pixel pipeline stage. Converts pixel coordinates    |
// |            into screen-buffer word addresses and font ROM addresses.     |
// |            Serialises one monochrome pixel per clock and overlays a      |
// |            blinking underline cursor. Sync and active are delayed to     |
// |            line up with the pixel.                                       |
// | Ports    : clk_i/rst_i        pixel clock, sync active-high reset       |
// |            hcount_i/vcount_i  pixel coordinates, active_i visible flag  |
// |            hsync_i/vsync_i    timing-generator syncs (active low)       |
// |            vr_addr_o/buf_data_i    screen buffer read port (1-cycle)    |
// |            font_addr_o/font_data_i font ROM read port (1-cycle)         |
// |            cursor_en_i/cursor_tile_i cursor control                     |
// |            pixel_o/active_o/hsync_o/vsync_o  aligned outputs (5 cycles) |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vga_tile_fetch #(
  parameter int H_TILES         = 80,
  parameter int V_TILES         = 30,
  parameter int WORDS_PER_ROW   = 20,
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 28,
  parameter int SINGLE_DATA     = 7,
  parameter int FONT_ADDR_WIDTH = 11,
  parameter int TILE_IDX_WIDTH  = 12,
  parameter int BLINK_FRAMES    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [9:0]                 hcount_i,
  input  logic [9:0]                 vcount_i,
  input  logic                       active_i,
  input  logic                       hsync_i,
  input  logic                       vsync_i,
  output logic [ADDR_WIDTH-1:0]      vr_addr_o,
  input  logic [DATA_WIDTH-1:0]      buf_data_i,
  output logic [FONT_ADDR_WIDTH-1:0] font_addr_o,
  input  logic [7:0]                 font_data_i,
  input  logic                       cursor_en_i,
  input  logic [TILE_IDX_WIDTH-1:0]  cursor_tile_i,
  output logic                       pixel_o,
  output logic                       active_o,
  output logic                       hsync_o,
  output logic                       vsync_o
);

  localparam int          BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [31:0] TILE_LIMIT = 32'(H_TILES * V_TILES);

  // Stage registers
  logic [ADDR_WIDTH-1:0]      vr_addr_q;
  logic [FONT_ADDR_WIDTH-1:0] font_addr_q;
  logic                       pixel_q;
  logic [1:0]                 lane1_q, lane2_q;
  logic [3:0]                 row1_q, row2_q;
  logic [2:0]                 bit1_q, bit2_q, bit3_q, bit4_q;
  logic                       match1_q, match2_q, match3_q, match4_q;
  // Bit k holds the flag captured k+1 edges ago; bit 4 is the output tap
  logic [4:0]                 act_sr_q;
  logic [4:0]                 hs_sr_q;
  logic [4:0]                 vs_sr_q;
  logic                       vsync_prev_q;
  logic [BLINK_W-1:0]         blink_cnt_q;
  logic                       blink_phase_q;

  // Combinational S1/S3 helpers
  logic [31:0]            tile_idx_d;
  logic                   match_d;
  logic [SINGLE_DATA-1:0] char_d;
  logic                   vsync_fall_d;

  always_comb begin
    tile_idx_d = 32'(vcount_i[9:4]) * 32'(H_TILES) + 32'(hcount_i[9:3]);
    // Out-of-range cursor indices are rejected explicitly so that blanking
    // coordinates (which can produce large tile indices) never alias them.
    match_d = cursor_en_i
           && (tile_idx_d == 32'(cursor_tile_i))
           && (32'(cursor_tile_i) < TILE_LIMIT)
           && (vcount_i[3:0] >= 4'd14);
  end

  // Lane 0 is the least significant character and the leftmost tile
  always_comb begin
    char_d = buf_data_i[SINGLE_DATA-1:0];
    case (lane2_q)
      2'd1:    char_d = buf_data_i[SINGLE_DATA   +: SINGLE_DATA];
      2'd2:    char_d = buf_data_i[2*SINGLE_DATA +: SINGLE_DATA];
      2'd3:    char_d = buf_data_i[3*SINGLE_DATA +: SINGLE_DATA];
      default: char_d = buf_data_i[SINGLE_DATA-1:0];
    endcase
  end

  assign vsync_fall_d = vsync_prev_q & ~vsync_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vr_addr_q     <= '0;
      font_addr_q   <= '0;
      pixel_q       <= 1'b0;
      lane1_q       <= '0;
      lane2_q       <= '0;
      row1_q        <= '0;
      row2_q        <= '0;
      bit1_q        <= '0;
      bit2_q        <= '0;
      bit3_q        <= '0;
      bit4_q        <= '0;
      match1_q      <= 1'b0;
      match2_q      <= 1'b0;
      match3_q      <= 1'b0;
      match4_q      <= 1'b0;
      act_sr_q      <= '0;
      hs_sr_q       <= '1;
      vs_sr_q       <= '1;
      vsync_prev_q  <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      // S1: address generation and sideband capture
      if (active_i) begin
        vr_addr_q <= ADDR_WIDTH'(32'(vcount_i[9:4]) * 32'(WORDS_PER_ROW)
                                + 32'(hcount_i[9:5]));
      end
      lane1_q  <= hcount_i[4:3];
      row1_q   <= vcount_i[3:0];
      bit1_q   <= hcount_i[2:0];
      match1_q <= match_d;

      // S2: buffer read in flight
      lane2_q  <= lane1_q;
      row2_q   <= row1_q;
      bit2_q   <= bit1_q;
      match2_q <= match1_q;

      // S3: character code plus glyph row forms the font address
      font_addr_q <= FONT_ADDR_WIDTH'({char_d, row2_q});
      bit3_q      <= bit2_q;
      match3_q    <= match2_q;

      // S4: font ROM read in flight
      bit4_q   <= bit3_q;
      match4_q <= match3_q;

      // S5: bit 7 of the font row is the leftmost pixel of the tile
      pixel_q <= act_sr_q[3]
               & (font_data_i[~bit4_q] | (match4_q & blink_phase_q));

      act_sr_q <= {act_sr_q[3:0], active_i};
      hs_sr_q  <= {hs_sr_q[3:0], hsync_i};
      vs_sr_q  <= {vs_sr_q[3:0], vsync_i};

      // Frame counter for the cursor blink, advanced on vsync falling edges
      vsync_prev_q <= vsync_i;
      if (vsync_fall_d) begin
        if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
      end
    end
  end

  assign vr_addr_o   = vr_addr_q;
  assign font_addr_o = font_addr_q;
  assign pixel_o     = pixel_q;
  assign active_o    = act_sr_q[4];
  assign hsync_o     = hs_sr_q[4];
  assign vsync_o     = vs_sr_q[4];

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_tile_fetch                                             |
// | Purpose  : Self-checking bench for vga_tile_fetch with behavioural       |
// |            screen buffer and font ROM (registered one-cycle reads).      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vga_tile_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount;
  logic        active, hsync, vsync;
  logic [9:0]  vr_addr;
  logic [27:0] buf_q;
  logic [10:0] font_addr;
  logic [7:0]  font_q;
  logic        cursor_en;
  logic [11:0] cursor_tile;
  logic        pixel, active_out, hsync_out, vsync_out;

  logic [27:0] buf_mem [0:1023];
  logic [7:0]  rom     [0:2047];

  int n_pass  = 0;
  int n_total = 0;

  always #20 clk = ~clk;

  always @(posedge clk) begin
    buf_q  <= buf_mem[vr_addr];
    font_q <= rom[font_addr];
  end

  vga_tile_fetch dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hcount_i     (hcount),
    .vcount_i     (vcount),
    .active_i     (active),
    .hsync_i      (hsync),
    .vsync_i      (vsync),
    .vr_addr_o    (vr_addr),
    .buf_data_i   (buf_q),
    .font_addr_o  (font_addr),
    .font_data_i  (font_q),
    .cursor_en_i  (cursor_en),
    .cursor_tile_i(cursor_tile),
    .pixel_o      (pixel),
    .active_o     (active_out),
    .hsync_o      (hsync_out),
    .vsync_o      (vsync_out)
  );

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       a;
    logic       hs;
    logic       vs;
    logic [3:0] exp;   // {pixel, active, hsync, vsync}
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, want);
  endtask

  task automatic drive_idle();
    hcount = 10'd700; vcount = 10'd0; active = 1'b0; hsync = 1'b1; vsync = 1'b1;
  endtask

  // Streams 16 consecutive pixels of one line and checks pixel/active at
  // the 5-cycle output latency; want[k] is the pixel for hcount h0+k.
  task automatic run_line(input logic [9:0] v, input logic [9:0] h0,
                          input logic [15:0] want, input string nm);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i >= 5) begin
        chk($sformatf("%s px%0d", nm, i - 5), {31'd0, pixel}, {31'd0, want[i-5]});
        chk($sformatf("%s act%0d", nm, i - 5), {31'd0, active_out}, 32'd1);
      end
      if (i < 16) begin
        hcount = h0 + 10'(i); vcount = v; active = 1'b1; hsync = 1'b1; vsync = 1'b1;
      end else begin
        drive_idle();
      end
    end
  endtask

  task automatic pulse_vsync(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vsync = 1'b0;
      @(negedge clk); vsync = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] pa, pb, rp;
    for (int i = 0; i < 1024; i++) buf_mem[i] = '0;
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    buf_mem[0]    = {7'h41, 21'd0};          // lane 3 = 'A'
    buf_mem[43]   = 28'h0ABCDEF;             // lane 0 = 7'h6F
    buf_mem[9]    = 28'(7'h22) << 7;         // lane 1 = 7'h22
    rom[11'h410]  = 8'b1000_0001;
    rom[11'h6F5]  = 8'b1011_0010;
    rom[11'h6F6]  = 8'hFF;                   // what blanking would fetch
    rom[11'h220]  = 8'b0000_0111;

    pa = 8'b1000_0001;
    pb = 8'b1011_0010;
    for (int k = 0; k < 8; k++) begin
      tbl[k]   = '{h: 10'(24 + k), v: 10'd0,  a: 1'b1, hs: 1'b1, vs: 1'b1,
                   exp: {pa[7-k], 3'b111}};
      tbl[k+8] = '{h: 10'(96 + k), v: 10'd37, a: 1'b1, hs: 1'b1, vs: 1'b1,
                   exp: {pb[7-k], 3'b111}};
    end
    for (int k = 16; k < 24; k++) begin
      logic hs_b, vs_b;
      hs_b = (k != 18);
      vs_b = (k != 20);
      tbl[k] = '{h: 10'(640 + k - 16), v: 10'd38, a: 1'b0, hs: hs_b, vs: vs_b,
                 exp: {1'b0, 1'b0, hs_b, vs_b}};
    end

    // Reset state
    rst = 1'b1; cursor_en = 1'b0; cursor_tile = 12'd0;
    drive_idle();
    @(negedge clk); @(negedge clk);
    chk("rst vr_addr",   {22'd0, vr_addr},   32'd0);
    chk("rst font_addr", {21'd0, font_addr}, 32'd0);
    chk("rst pixel",     {31'd0, pixel},      32'd0);
    chk("rst active",    {31'd0, active_out}, 32'd0);
    chk("rst hsync",     {31'd0, hsync_out},  32'd1);
    chk("rst vsync",     {31'd0, vsync_out},  32'd1);
    rst = 1'b0;

    // Address mapping: (100,37) -> word 43, lane 0 char 6F, row 5
    @(negedge clk);
    hcount = 10'd100; vcount = 10'd37; active = 1'b1;
    @(negedge clk);
    drive_idle();
    chk("map vr_addr", {22'd0, vr_addr}, 32'd43);
    @(negedge clk); @(negedge clk);
    chk("map font_addr", {21'd0, font_addr}, 32'h6F5);

    // Lane 3 of word 0 at (24,0)
    @(negedge clk);
    hcount = 10'd24; vcount = 10'd0; active = 1'b1;
    @(negedge clk);
    drive_idle();
    chk("lane vr_addr", {22'd0, vr_addr}, 32'd0);
    @(negedge clk); @(negedge clk);
    chk("lane font_addr", {21'd0, font_addr}, 32'h410);
    repeat (6) @(negedge clk);

    // Table: record j driven before edge j, observed after edge j+4
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      if (i >= 5)
        chk($sformatf("tbl[%0d] {pix,act,hs,vs}", i - 5),
            {28'd0, pixel, active_out, hsync_out, vsync_out},
            {28'd0, tbl[i-5].exp});
      if (i < 24) begin
        hcount = tbl[i].h; vcount = tbl[i].v; active = tbl[i].a;
        hsync = tbl[i].hs; vsync = tbl[i].vs;
      end else begin
        drive_idle();
      end
    end

    // Leave the blink counter part-way so a missing reset would show later
    pulse_vsync(3);
    repeat (6) @(negedge clk);

    // Reset for one cycle at hcount=300 on line 0
    rp = 8'b0000_0111;   // pixels for hcount 301..308
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("mid rst vr_addr",   {22'd0, vr_addr},   32'd0);
        chk("mid rst font_addr", {21'd0, font_addr}, 32'd0);
        chk("mid rst pixel",     {31'd0, pixel},      32'd0);
        chk("mid rst active",    {31'd0, active_out}, 32'd0);
        chk("mid rst hsync",     {31'd0, hsync_out},  32'd1);
        chk("mid rst vsync",     {31'd0, vsync_out},  32'd1);
      end else if (i >= 6 && i <= 9) begin
        chk($sformatf("flush %0d {pix,act}", i), {30'd0, pixel, active_out}, 32'd0);
      end else if (i >= 10) begin
        chk($sformatf("resume h%0d pix", 291 + i), {31'd0, pixel}, {31'd0, rp[i-10]});
        chk($sformatf("resume h%0d act", 291 + i), {31'd0, active_out}, 32'd1);
      end
      hcount = 10'(296 + i); vcount = 10'd0; active = 1'b1; hsync = 1'b1; vsync = 1'b1;
      rst = (i == 4);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (6) @(negedge clk);

    // Cursor at tile 81 (row 1, col 1); counter is 0 after the reset above
    cursor_en = 1'b1; cursor_tile = 12'd81;
    pulse_vsync(15);
    run_line(10'd30, 10'd0, 16'h0000, "cur 15 edges v30");
    pulse_vsync(1);
    run_line(10'd30, 10'd0, 16'hFF00, "cur on v30");
    run_line(10'd31, 10'd8, 16'h00FF, "cur on v31");
    run_line(10'd29, 10'd0, 16'h0000, "cur on v29");
    run_line(10'd46, 10'd8, 16'h0000, "cur on v46");
    cursor_en = 1'b0;
    run_line(10'd30, 10'd0, 16'h0000, "cur disabled");
    cursor_en = 1'b1; cursor_tile = 12'd2400;
    run_line(10'd30, 10'd0, 16'h0000, "cur oob on");
    run_line(10'd479, 10'd624, 16'h0000, "cur oob last");
    cursor_en = 1'b0;
    pulse_vsync(16);
    cursor_en = 1'b1; cursor_tile = 12'd81;
    run_line(10'd30, 10'd0, 16'h0000, "cur 32 edges v30");
    cursor_tile = 12'd2400;
    run_line(10'd30, 10'd0, 16'h0000, "cur oob off");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/vga_tile_fetch.md
Name: vga_tile_fetch

Overview:
- Pixel-pipeline stage directly downstream of the screen buffer.
- Turns the timing generator's pixel coordinates into:
  - buffer read addresses,
  - per-tile font ROM addresses,
  - one serialised monochrome pixel per clock.
- Delays sync/active to match pipeline latency; overlays a blinking underline cursor.
- Sits between the screen buffer/font ROM and the VGA output pins, on the 25 MHz pixel clock.

Parameters:
- H_TILES, 80, tile columns (640/8)
- V_TILES, 30, tile rows (480/16)
- WORDS_PER_ROW, 20, buffer words per tile row (H_TILES/4)
- ADDR_WIDTH, 10, buffer word address width
- DATA_WIDTH, 28, buffer word width (4 chars × 7 bits)
- SINGLE_DATA, 7, char code width
- FONT_ADDR_WIDTH, 11, font ROM address width (128 chars × 16 rows)
- TILE_IDX_WIDTH, 12, cursor tile index width (0..2399)
- BLINK_FRAMES, 16, frames per cursor blink half-period

Ports:
- clk_i, input, 1, 25 MHz pixel clock
- rst_i, input, 1, synchronous active-high reset
- hcount_i, input, 10, current pixel column (0..639 when active)
- vcount_i, input, 10, current pixel row (0..479 when active)
- active_i, input, 1, visible-area flag for hcount_i/vcount_i
- hsync_i, input, 1, horizontal sync from timing generator (active low)
- vsync_i, input, 1, vertical sync from timing generator (active low)
- vr_addr_o, output, ADDR_WIDTH, screen buffer display read address
- buf_data_i, input, DATA_WIDTH, buffer display data, valid 1 cycle after vr_addr_o registers
- font_addr_o, output, FONT_ADDR_WIDTH, font ROM address = {char, row[3:0]}
- font_data_i, input, 8, font ROM row bits, valid 1 cycle after font_addr_o registers; bit 7 = leftmost pixel
- cursor_en_i, input, 1, cursor enable
- cursor_tile_i, input, TILE_IDX_WIDTH, cursor tile index = row*80 + col
- pixel_o, output, 1, pixel value (1 = foreground)
- active_o, output, 1, active_i delayed to align with pixel_o
- hsync_o, output, 1, hsync_i delayed to align with pixel_o
- vsync_o, output, 1, vsync_i delayed to align with pixel_o

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - vr_addr_o=0, font_addr_o=0, pixel_o=0, active_o=0, hsync_o=1, vsync_o=1.
  - All pipeline valid/active flags cleared; blink counter=0; blink phase=0.
- Pipeline: fixed 5-cycle latency from (hcount_i, vcount_i, active_i, syncs) to (pixel_o, active_o, syncs_o).
- S1 (edge 1):
  - When active_i=1: vr_addr_o <= (vcount_i>>4)*WORDS_PER_ROW + (hcount_i>>5).
  - When active_i=0: vr_addr_o holds its value.
  - Register lane = hcount_i[4:3], row = vcount_i[3:0], bit = hcount_i[2:0], active.
  - Register cursor match = cursor_en_i && tile index ((vcount_i>>4)*H_TILES + (hcount_i>>3)) == cursor_tile_i && row>=14.
- S2 (edge 2): buffer samples address; sideband (lane, row, bit, active, match) advances one stage.
- S3 (edge 3): font_addr_o <= {buf_data_i[lane*7 +: 7], row}. Lane 0 = bits [6:0] = leftmost tile of the word.
- S4 (edge 4): ROM samples address; sideband advances.
- S5 (edge 5):
  - pixel_o <= active && (font_data_i[7-bit] | (match && blink_phase)).
  - pixel_o is 0 whenever the delayed active is 0.
- Sync/active: 5-deep shift registers; no modification of polarity or width.
- Blink counter:
  - Increments on each falling edge of vsync_i, detected with an internal registered copy of vsync_i.
  - On reaching BLINK_FRAMES-1, wraps to 0 and toggles blink_phase.
- cursor_tile_i >= 2400 never matches; cursor_en_i=0 suppresses overlay, but the counter keeps running.
- cursor_en_i and cursor_tile_i are sampled in S1 only; changing mid-line affects only later pixels.
- Reset mid-frame: pipeline flushes. Outputs stay at reset values until 5 cycles after the first post-reset pixel enters.
- Arithmetic widths:
  - Address products use full-width intermediates (max 599, max 2399) before truncation to ADDR_WIDTH / TILE_IDX_WIDTH.
  - No wrap occurs in the valid range.

Test Plan:
- Address mapping: hcount=100, vcount=37, active=1 -> after 1 cycle vr_addr_o=2*20+3=43; with buf_data_i=28'h0ABCDEF at S3, lane=hcount[4:3]=0 -> font_addr_o={7'h6F, 4'd5}=11'h6F5.
- Lane select and pixel order: hcount=24..31, vcount=0, buf word lane 3=7'h41, font_data_i=8'b1000_0001 -> font_addr_o={7'h41, 4'd0}; pixel_o sequence 1,0,0,0,0,0,0,1 starting 5 cycles after hcount=24.
- Latency/sync alignment: single-cycle low pulse on hsync_i -> hsync_o low exactly 5 cycles later, one cycle wide; active_i falling edge -> active_o falls 5 cycles later; pixel_o=0 in blanking even with font_data_i=8'hFF.
- Cursor blink: cursor_en_i=1, cursor_tile_i=81 (row 1, col 1), font_data_i=0.
  - Frames 0..15: pixel_o=0.
  - After 16 vsync falling edges: pixel_o=1 for hcount 8..15, vcount 30..31 only.
  - After 32 edges: 0 again.
- Out-of-range cursor: cursor_tile_i=2400 -> no overlay in any phase.
- Reset mid-line: assert rst_i for 1 cycle at hcount=300 -> next cycle pixel_o=0, hsync_o=1, vsync_o=1, active_o=0, vr_addr_o=0, blink counter=0; correct pixels resume 5 cycles after release.
